// File: rtl/fru_ctx_engine.sv
// fru_ctx_engine: multi-context filter/response unit with a serial, checksum-verified
// configuration loader and run-time context switching.
module fru_ctx_engine #(
    parameter  int M       = 4,
    parameter  int CTRL_W  = 16,
    parameter  int CTX     = 4,
    parameter  int TIMEOUT = 64,
    localparam int CW      = (CTX > 1) ? $clog2(CTX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] Qin,
    output logic [CTRL_W-1:0] Qout,
    input  logic [M-1:0]      Trigger,
    input  logic              BitStreamSerialIn,
    input  logic              BitStreamValid,
    input  logic              CtxSwitchReq,
    input  logic [CW-1:0]     CtxSel,
    output logic [CW-1:0]     ActiveCtx,
    output logic              LoadBusy,
    output logic              LoadDone,
    output logic              LoadErr
);

    localparam int TSEL_W = (M > 1) ? $clog2(M) : 1;
    localparam int FW     = 3 + TSEL_W;
    localparam int P      = CTRL_W * FW;
    localparam int CNT_W  = $clog2(P + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [1:0] MODE_FORCE  = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_STICKY = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    idle_q, idle_d;
    logic [7:0]         hdr_q, hdr_d;
    logic [CW-1:0]      tgt_q, tgt_d;
    logic [7:0]         sum_q, sum_d;
    logic               bad_q, bad_d;
    logic [P-1:0]       shadow_q, shadow_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               commit;
    logic [7:0]         hdr_full;
    logic               chk_bad;

    logic [P-1:0]       cfg_q [CTX];
    logic [P-1:0]       cfg_act;
    logic [CW-1:0]      act_q;

    logic [CTRL_W-1:0]  hold_flag_q, hold_flag_d;
    logic [CTRL_W-1:0]  hold_val_q, hold_val_d;
    logic [CTRL_W-1:0]  sticky_q, sticky_d;
    logic               flag_clr;

    logic [CTRL_W-1:0][1:0]        mode_w;
    logic [CTRL_W-1:0][TSEL_W-1:0] tsel_w;
    logic [CTRL_W-1:0]             cst_w;
    logic [CTRL_W-1:0]             trig_w;

    // Loader: header, payload shifted into the shadow, then running-XOR checksum compare.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        hdr_d    = hdr_q;
        tgt_d    = tgt_q;
        sum_d    = sum_q;
        bad_d    = bad_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        commit   = 1'b0;
        hdr_full = {hdr_q[6:0], BitStreamSerialIn};
        chk_bad  = bad_q | (BitStreamSerialIn != sum_q[cnt_q[2:0]]);
        case (state_q)
            S_IDLE: begin
                idle_d = '0;
                cnt_d  = '0;
                if (BitStreamValid) begin
                    hdr_d   = {7'd0, BitStreamSerialIn};
                    sum_d   = '0;
                    bad_d   = 1'b0;
                    state_d = S_HDR;
                end
            end
            default: begin
                if (!BitStreamValid) begin
                    if (idle_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idle_d = idle_q + TO_W'(1);
                    end
                end else begin
                    idle_d = '0;
                    cnt_d  = cnt_q + CNT_W'(1);
                    case (state_q)
                        S_HDR: begin
                            hdr_d = hdr_full;
                            if (cnt_q == CNT_W'(6)) begin
                                cnt_d = '0;
                                if (hdr_full[7:4] == 4'hA && int'(hdr_full[3:2]) < CTX) begin
                                    tgt_d   = CW'(hdr_full[3:2]);
                                    state_d = S_PAY;
                                end else begin
                                    err_d   = 1'b1;
                                    state_d = S_IDLE;
                                end
                            end
                        end
                        S_PAY: begin
                            shadow_d = {shadow_q[P-2:0], BitStreamSerialIn};
                            sum_d[cnt_q[2:0]] = sum_q[cnt_q[2:0]] ^ BitStreamSerialIn;
                            if (cnt_q == CNT_W'(P - 1)) begin
                                cnt_d   = '0;
                                state_d = S_CHK;
                            end
                        end
                        default: begin
                            bad_d = chk_bad;
                            if (cnt_q == CNT_W'(7)) begin
                                state_d = S_IDLE;
                                if (chk_bad) begin
                                    err_d = 1'b1;
                                end else begin
                                    commit = 1'b1;
                                    done_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        hdr_q      <= hdr_d;
        tgt_q      <= tgt_d;
        sum_q      <= sum_d;
        bad_q      <= bad_d;
        shadow_q   <= shadow_d;
        hold_val_q <= hold_val_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CTX; c++) cfg_q[c] <= '0;
        end else if (commit) begin
            cfg_q[tgt_q] <= shadow_q;
        end
    end

    assign cfg_act  = cfg_q[act_q];
    assign flag_clr = CtxSwitchReq | (commit & (tgt_q == act_q));

    always_comb begin
        mode_w = '0;
        tsel_w = '0;
        cst_w  = '0;
        trig_w = '0;
        for (int i = 0; i < CTRL_W; i++) begin
            mode_w[i] = cfg_act[i*FW + TSEL_W + 1 +: 2];
            cst_w[i]  = cfg_act[i*FW + TSEL_W];
            tsel_w[i] = cfg_act[i*FW +: TSEL_W];
            trig_w[i] = (int'(tsel_w[i]) < M) ? Trigger[tsel_w[i]] : 1'b0;
        end
    end

    // Datapath: per-signal mode applied combinationally; hold/sticky state updated at the edge.
    always_comb begin
        Qout        = Qin;
        hold_flag_d = hold_flag_q;
        hold_val_d  = hold_val_q;
        sticky_d    = sticky_q;
        for (int i = 0; i < CTRL_W; i++) begin
            case (mode_w[i])
                MODE_FORCE: begin
                    if (trig_w[i]) Qout[i] = cst_w[i];
                end
                MODE_HOLD: begin
                    if (hold_flag_q[i]) begin
                        Qout[i]        = hold_val_q[i];
                        hold_flag_d[i] = trig_w[i];
                    end else if (trig_w[i]) begin
                        hold_flag_d[i] = 1'b1;
                        hold_val_d[i]  = Qin[i];
                    end
                end
                MODE_STICKY: begin
                    if (trig_w[i] | sticky_q[i]) Qout[i] = cst_w[i];
                    if (trig_w[i]) sticky_d[i] = 1'b1;
                end
                default: ;
            endcase
        end
        if (flag_clr) begin
            hold_flag_d = '0;
            sticky_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q       <= '0;
            hold_flag_q <= '0;
            sticky_q    <= '0;
        end else begin
            if (CtxSwitchReq) act_q <= CtxSel;
            hold_flag_q <= hold_flag_d;
            sticky_q    <= sticky_d;
        end
    end

    assign ActiveCtx = act_q;
    assign LoadBusy  = (state_q != S_IDLE);
    assign LoadDone  = done_q;
    assign LoadErr   = err_q;

endmodule

// File: tb/tb_fru_ctx_engine.sv
// Bench for fru_ctx_engine: a behavioural model predicts every cycle's outputs into a
// queue; an independent negedge monitor pops and compares against the DUT.
module tb_fru_ctx_engine;
    localparam int M       = 4;
    localparam int CTRL_W  = 16;
    localparam int CTX     = 4;
    localparam int TIMEOUT = 64;
    localparam int FW      = 5;
    localparam int P       = CTRL_W * FW;

    logic              clk = 1'b0;
    logic              rst;
    logic [CTRL_W-1:0] Qin, Qout;
    logic [M-1:0]      Trigger;
    logic              BitStreamSerialIn, BitStreamValid, CtxSwitchReq;
    logic [1:0]        CtxSel, ActiveCtx;
    logic              LoadBusy, LoadDone, LoadErr;

    fru_ctx_engine #(.M(M), .CTRL_W(CTRL_W), .CTX(CTX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .Qin(Qin), .Qout(Qout), .Trigger(Trigger),
        .BitStreamSerialIn(BitStreamSerialIn), .BitStreamValid(BitStreamValid),
        .CtxSwitchReq(CtxSwitchReq), .CtxSel(CtxSel), .ActiveCtx(ActiveCtx),
        .LoadBusy(LoadBusy), .LoadDone(LoadDone), .LoadErr(LoadErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CTRL_W-1:0] q;
        logic [1:0]        act;
        logic              busy;
        logic              done;
        logic              err;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Behavioural model state: decoded per-signal configuration for each context.
    logic [1:0]        mmode  [CTX][CTRL_W];
    logic              mconst [CTX][CTRL_W];
    logic [1:0]        mtsel  [CTX][CTRL_W];
    int                mact;
    logic [CTRL_W-1:0] mhf, mhv, mst;
    logic              fb[$];
    bit                infr;
    int                fidle;
    bit                pdone, perr;

    // Stimulus globals.
    logic [CTRL_W-1:0] q_g;
    logic [M-1:0]      trig_g;
    logic              sw_g, rst_g;
    logic [1:0]        sel_g;
    bit                rand_io = 1'b0;
    int                sw_rate = 0;
    logic [1:0]        f_mode [CTRL_W];
    logic              f_c    [CTRL_W];
    logic [1:0]        f_ts   [CTRL_W];

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty got=0 exp=1 t=%0t", $time);
            end else begin
                e = expq.pop_front();
                cmp("Qout", 32'(Qout), 32'(e.q));
                cmp("ActiveCtx", 32'(ActiveCtx), 32'(e.act));
                cmp("LoadBusy", 32'(LoadBusy), 32'(e.busy));
                cmp("LoadDone", 32'(LoadDone), 32'(e.done));
                cmp("LoadErr", 32'(LoadErr), 32'(e.err));
            end
        end
    end

    task automatic model_reset();
        for (int c = 0; c < CTX; c++)
            for (int i = 0; i < CTRL_W; i++) begin
                mmode[c][i] = 2'b00; mconst[c][i] = 1'b0; mtsel[c][i] = 2'b00;
            end
        mact = 0; mhf = '0; mhv = '0; mst = '0;
        fb.delete(); infr = 1'b0; fidle = 0; pdone = 1'b0; perr = 1'b0;
    endtask

    // One clock cycle: drive inputs, predict this cycle's outputs, advance the model.
    task automatic tick(input logic bsv, input logic bsi);
        exp_t              e;
        logic [CTRL_W-1:0] nhf, nhv, nst;
        logic [1:0]        md, ts;
        logic              c, t, sw, ok, x;
        logic [1:0]        sel;
        logic [3:0]        hsync;
        logic [P-1:0]      plr;
        bit                cm;
        int                ctgt;
        sw = sw_g; sel = sel_g;
        if (rand_io) begin
            q_g = CTRL_W'($urandom); trig_g = M'($urandom);
            if (sw_rate > 0 && int'($urandom_range(99, 0)) < sw_rate) begin
                sw = 1'b1; sel = 2'($urandom);
            end
        end
        Qin = q_g; Trigger = trig_g; rst = rst_g; CtxSwitchReq = sw; CtxSel = sel;
        BitStreamValid = bsv; BitStreamSerialIn = bsi;

        nhf = mhf; nhv = mhv; nst = mst;
        e.q = q_g;
        for (int i = 0; i < CTRL_W; i++) begin
            md = mmode[mact][i]; c = mconst[mact][i]; ts = mtsel[mact][i];
            t  = (int'(ts) < M) ? trig_g[ts] : 1'b0;
            if (md == 2'd1 && t) e.q[i] = c;
            if (md == 2'd2) begin
                if (mhf[i]) begin
                    e.q[i] = mhv[i]; nhf[i] = t;
                end else if (t) begin
                    nhf[i] = 1'b1; nhv[i] = q_g[i];
                end
            end
            if (md == 2'd3) begin
                if (t || mst[i]) e.q[i] = c;
                if (t) nst[i] = 1'b1;
            end
        end
        e.act = 2'(mact); e.busy = infr; e.done = pdone; e.err = perr;
        expq.push_back(e);

        pdone = 1'b0; perr = 1'b0; cm = 1'b0; ctgt = 0;
        if (bsv) begin
            fb.push_back(bsi); infr = 1'b1; fidle = 0;
            if (fb.size() == 8) begin
                hsync = {fb[0], fb[1], fb[2], fb[3]};
                if (hsync != 4'hA || int'({fb[4], fb[5]}) >= CTX) begin
                    perr = 1'b1; infr = 1'b0; fb.delete();
                end
            end else if (fb.size() == 8 + P + 8) begin
                ok = 1'b1;
                for (int m = 0; m < 8; m++) begin
                    x = 1'b0;
                    for (int n = m; n < P; n += 8) x = x ^ fb[8 + n];
                    if (x != fb[8 + P + m]) ok = 1'b0;
                end
                ctgt = int'({fb[4], fb[5]});
                if (ok) begin
                    cm = 1'b1;
                    for (int j = 0; j < P; j++) plr[j] = fb[8 + (P - 1 - j)];
                end else begin
                    perr = 1'b1;
                end
                infr = 1'b0; fb.delete();
            end
        end else if (infr) begin
            fidle++;
            if (fidle == TIMEOUT) begin
                perr = 1'b1; infr = 1'b0; fb.delete(); fidle = 0;
            end
        end

        if (rst_g) begin
            model_reset();
        end else begin
            if (sw || (cm && ctgt == mact)) begin
                nhf = '0; nst = '0;
            end
            mhf = nhf; mhv = nhv; mst = nst;
            if (cm) begin
                for (int i = 0; i < CTRL_W; i++) begin
                    mmode[ctgt][i]  = {plr[i*FW + 4], plr[i*FW + 3]};
                    mconst[ctgt][i] = plr[i*FW + 2];
                    mtsel[ctgt][i]  = {plr[i*FW + 1], plr[i*FW]};
                end
            end
            if (sw) mact = int'(sel);
            pdone = cm;
        end
        @(posedge clk); #1;
    endtask

    task automatic clr_fields();
        for (int i = 0; i < CTRL_W; i++) begin
            f_mode[i] = 2'b00; f_c[i] = 1'b0; f_ts[i] = 2'b00;
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < CTRL_W; i++) begin
            f_mode[i] = 2'($urandom); f_c[i] = 1'($urandom); f_ts[i] = 2'($urandom);
        end
    endtask

    // Serialise a frame from f_* fields. flip: payload bit to corrupt after the checksum is
    // formed; stall_at / rst_at: bit index at which to go silent or reset instead.
    task automatic send_frame(input int ctx, input bit use_ovr, input logic [7:0] hdr_ovr,
                              input int flip, input int stall_at, input int rst_at,
                              input int gap_max);
        logic [P-1:0] pl;
        logic [7:0]   hdr, cs;
        logic         bits[$];
        logic [1:0]   cx;
        cx = 2'(ctx);
        for (int i = 0; i < CTRL_W; i++) pl[i*FW +: FW] = {f_mode[i], f_c[i], f_ts[i]};
        hdr = use_ovr ? hdr_ovr : {4'hA, cx, 2'($urandom)};
        cs  = '0;
        for (int n = 0; n < P; n++) cs[n % 8] = cs[n % 8] ^ pl[P - 1 - n];
        for (int k = 0; k < 8; k++) bits.push_back(hdr[7 - k]);
        for (int n = 0; n < P; n++) bits.push_back((n == flip) ? ~pl[P - 1 - n] : pl[P - 1 - n]);
        for (int m = 0; m < 8; m++) bits.push_back(cs[m]);
        if (use_ovr) while (bits.size() > 8) void'(bits.pop_back());
        for (int k = 0; k < bits.size(); k++) begin
            if (k == stall_at) begin
                repeat (TIMEOUT) tick(1'b0, 1'b0);
                return;
            end
            if (k == rst_at) begin
                rst_g = 1'b1;
                tick(1'b0, 1'b0);
                tick(1'b0, 1'b0);
                rst_g = 1'b0;
                return;
            end
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick(1'b0, 1'b0);
            tick(1'b1, bits[k]);
        end
    endtask

    initial begin
        rst = 1'b1; Qin = '0; Trigger = '0; BitStreamSerialIn = 1'b0; BitStreamValid = 1'b0;
        CtxSwitchReq = 1'b0; CtxSel = '0;
        q_g = '0; trig_g = '0; sw_g = 1'b0; sel_g = '0; rst_g = 1'b0;
        clr_fields();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Post-reset bypass with toggling triggers.
        q_g = 16'hA5C3;
        for (int k = 0; k < 8; k++) begin
            trig_g = M'($urandom);
            tick(1'b0, 1'b0);
        end

        // Force on signal 3 from Trigger[2].
        trig_g = '0; q_g = '0;
        f_mode[3] = 2'b01; f_c[3] = 1'b1; f_ts[3] = 2'd2;
        send_frame(0, 1'b0, 8'h00, -1, -1, -1, 0);
        tick(1'b0, 1'b0);
        trig_g = 4'b0100; tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        trig_g = 4'b0000; q_g = 16'h0008; tick(1'b0, 1'b0);
        q_g = '0; tick(1'b0, 1'b0);

        // Hold on signal 5 (Trigger[0]) and sticky force-to-0 on signal 7 (Trigger[1]).
        f_mode[5] = 2'b10; f_ts[5] = 2'd0;
        f_mode[7] = 2'b11; f_c[7] = 1'b0; f_ts[7] = 2'd1;
        send_frame(0, 1'b0, 8'h00, -1, -1, -1, 2);
        tick(1'b0, 1'b0);
        q_g = 16'h0020; trig_g = 4'b0001; tick(1'b0, 1'b0);
        q_g = 16'h0000; repeat (3) tick(1'b0, 1'b0);
        trig_g = 4'b0000; repeat (3) tick(1'b0, 1'b0);
        q_g = 16'hFFFF; trig_g = 4'b0010; tick(1'b0, 1'b0);
        trig_g = 4'b0000; repeat (5) tick(1'b0, 1'b0);
        sw_g = 1'b1; sel_g = 2'd0; tick(1'b0, 1'b0);
        sw_g = 1'b0; repeat (3) tick(1'b0, 1'b0);

        // Corrupted payload, then a bad header.
        rand_fields();
        send_frame(0, 1'b0, 8'h00, 13, -1, -1, 1);
        rand_io = 1'b1; repeat (6) tick(1'b0, 1'b0);
        send_frame(0, 1'b1, 8'h50, -1, -1, -1, 0);
        repeat (4) tick(1'b0, 1'b0);

        // Stall mid-payload until timeout.
        send_frame(1, 1'b0, 8'h00, -1, 28, -1, 0);
        repeat (4) tick(1'b0, 1'b0);

        // Load ctx2 behind the active ctx0, then switch to it.
        rand_fields();
        send_frame(2, 1'b0, 8'h00, -1, -1, -1, 1);
        repeat (2) tick(1'b0, 1'b0);
        sw_g = 1'b1; sel_g = 2'd2; tick(1'b0, 1'b0);
        sw_g = 1'b0; repeat (20) tick(1'b0, 1'b0);

        // Randomised frames, corruptions and context switches.
        sw_rate = 3;
        for (int f = 0; f < 14; f++) begin
            rand_fields();
            send_frame(int'($urandom_range(3, 0)), 1'b0, 8'h00,
                       ($urandom_range(3, 0) == 0) ? int'($urandom_range(P - 1, 0)) : -1,
                       -1, -1, 3);
            repeat ($urandom_range(12, 2)) tick(1'b0, 1'b0);
        end
        sw_rate = 0;

        // Reset in the middle of a frame.
        rand_fields();
        send_frame(3, 1'b0, 8'h00, -1, -1, 40, 0);
        repeat (10) tick(1'b0, 1'b0);

        mon_en = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fru_ctx_engine.md
Name: fru_ctx_engine

Overview:
- Multi-context successor to the FRU filter/response unit. Holds CTX complete filter configurations and applies the active one to a CTRL_W-bit controllable signal set under M trigger inputs.
- Adds the serial bitstream loader, checksum-verified commit, per-signal hold and sticky-force modes, and run-time context switching.
- Sits between the SMU trigger outputs and the patched SoC signals.

Parameters:
- M, 4: number of trigger inputs.
- CTRL_W, 16: controllable signal width.
- CTX, 4: number of configuration contexts (power of 2, at most 4).
- TSEL_W, $clog2(M): trigger-select field width (localparam).
- FW, 3+TSEL_W: per-signal field width (localparam).
- P, CTRL_W*FW: payload bits per context (localparam; 80 at defaults).
- TIMEOUT, 64: idle cycles allowed mid-frame before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- Qin  in  CTRL_W  controllable signals from the SoC.
- Qout  out  CTRL_W  filtered signals to the SoC.
- Trigger  in  M  SMU trigger vector.
- BitStreamSerialIn  in  1  serial config data.
- BitStreamValid  in  1  qualifies BitStreamSerialIn.
- CtxSwitchReq  in  1  request to switch the active context.
- CtxSel  in  $clog2(CTX)  target context for a switch.
- ActiveCtx  out  $clog2(CTX)  currently applied context.
- LoadBusy  out  1  a frame is in progress.
- LoadDone  out  1  one-cycle pulse: frame committed.
- LoadErr  out  1  one-cycle pulse: frame rejected.

Behaviour:
- Reset: all context stores zero, so every signal is in bypass and Qout=Qin.
  - ActiveCtx=0, FSM in IDLE, hold and sticky flags cleared.
  - LoadBusy, LoadDone and LoadErr all 0.
  - A reset mid-frame discards the shadow register; no context is modified.
- Field per signal i lives at payload bits [i*FW +: FW] as {mode[1:0], const, tsel}.
- Trigger t_i = Trigger[tsel]. If tsel >= M, t_i = 0.
- Mode 00, bypass: Qout[i] = Qin[i].
- Mode 01, force: Qout[i] = t_i ? const : Qin[i] (combinational).
- Mode 10, hold:
  - When t_i=1 and hold_flag=0, capture Qin[i] into hold_reg and set hold_flag; Qout[i]=Qin[i] in that cycle.
  - While hold_flag=1, Qout[i]=hold_reg.
  - hold_flag clears in the cycle after t_i is seen at 0.
- Mode 11, sticky force:
  - Qout[i] = (t_i | sticky) ? const : Qin[i].
  - sticky is set when t_i=1.
  - sticky clears only on rst, on a context switch, or on a commit to the active context.
- Loader FSM (states IDLE, HDR, PAY, CHK):
  - A bit is consumed only on a cycle with BitStreamValid=1.
  - IDLE: the first valid bit is header bit 7 and the FSM goes to HDR. LoadBusy=1 in every state except IDLE.
  - HDR: 8 bits, MSB first, {sync[3:0]=4'hA, ctx[1:0], rsvd[1:0]}.
    - Bad sync: LoadErr pulses the cycle after the 8th bit; FSM returns to IDLE.
    - ctx >= CTX: same handling as bad sync.
  - PAY: P bits. Received payload bit n (n=0 first) is stored at shadow index P-1-n.
  - CHK: 8 bits. Received checksum bit m must equal the XOR of all payload bits n with n mod 8 == m.
    - Match: copy shadow into context ctx; LoadDone pulses the next cycle.
    - Mismatch: LoadErr pulses; context unchanged.
    - Either way the FSM returns to IDLE.
  - Timeout: in HDR, PAY or CHK, TIMEOUT consecutive cycles with BitStreamValid=0 abort the frame. LoadErr pulses and the FSM returns to IDLE.
- Commit timing: the new config drives Qout from the cycle LoadDone is high. If ctx==ActiveCtx, all hold and sticky flags clear in that cycle.
- Context switch: on CtxSwitchReq=1, ActiveCtx<=CtxSel on the next edge, and hold and sticky flags clear.
  - A switch to the current context also clears the flags.
  - A switch in the same cycle as a commit: both apply, and the flags clear.
- Loading never stalls the datapath. A frame may target any context, including the active one.

Test Plan:
- Reset, then Qin=16'hA5C3 with all triggers toggling -> Qout=16'hA5C3, ActiveCtx=0, no pulses.
- Frame to ctx0 with signal 3 = {01,1,tsel=2} and good checksum -> LoadDone pulses once. Trigger[2]=1 with Qin[3]=0 gives Qout[3]=1; Trigger[2]=0 gives Qout[3]=Qin[3].
- Signal 5 in mode 10: Qin[5]=1 when Trigger[0] rises, then Qin[5]=0 while the trigger is held -> Qout[5] stays 1. One cycle after the trigger falls, Qout[5] follows Qin.
- Signal 7 in mode 11, const=0: one-cycle pulse on Trigger[1] -> Qout[7]=0 indefinitely. CtxSwitchReq to ctx0 -> Qout[7]=Qin[7] next cycle.
- Frame with one payload bit flipped -> LoadErr pulses and context contents are unchanged. Frame with header 8'h5_0 -> LoadErr after 8 bits.
- Frame stalled 64 cycles in PAY -> LoadErr, LoadBusy=0. Frame to ctx2 while ctx0 is active, then CtxSwitchReq with CtxSel=2 -> ActiveCtx=2 next cycle and ctx2 behaviour is applied.
